// File: rtl/fir_decim_buffer.sv
// Post-FIR stage: drops the pipeline-fill samples, decimates by DECIM and
// queues the kept samples in a show-ahead FIFO with a sticky overflow flag.
module fir_decim_buffer #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int SKIP       = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_sample_i,
  input  logic                          in_valid_i,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  input  logic                          clr_ovf_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [SW-1:0]     skip_q, skip_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [LW-1:0]     wr_q, wr_d;
  logic [LW-1:0]     rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic skipDone, keep, full, pop, push, drop;

  assign skipDone    = (skip_q == SW'(SKIP));
  assign keep        = in_valid_i && skipDone && (phase_q == '0);
  assign level_o     = wr_q - rd_q;
  assign full        = (level_o == LW'(FIFO_DEPTH));
  assign out_valid_o = (level_o != '0);
  assign pop         = out_valid_o && out_ready_i;
  // A pop frees the head slot in the same edge, so a full FIFO still accepts.
  assign push        = keep && (!full || pop);
  assign drop        = keep && full && !pop;
  assign out_data_o  = mem_q[rd_q[AW-1:0]];
  assign overflow_o  = ovf_q;

  always_comb begin
    skip_d  = skip_q;
    phase_d = phase_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    if (in_valid_i) begin
      if (!skipDone) begin
        skip_d = skip_q + SW'(1);
      end else begin
        phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
      end
    end
    if (push) wr_d = wr_q + LW'(1);
    if (pop)  rd_d = rd_q + LW'(1);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q  <= '0;
      phase_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      skip_q  <= skip_d;
      phase_q <= phase_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q[AW-1:0]] <= in_sample_i;
    end
  end

endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Downstream stage of the 9-tap FIR low-pass filter. It consumes the 100 MS/s filtered stream and discards the samples produced while the FIR pipeline fills after reset. It then decimates by a fixed factor and buffers the kept samples in a small FIFO with a valid/ready output port. A sink that stalls loses samples without corrupting the stream; each loss raises a sticky overflow flag.

## Interface

Parameters:
- DATA_W, 16: sample width, two's-complement signed.
- DECIM, 4: decimation factor. Legal range 1..16.
- SKIP, 6: number of valid input samples discarded after reset to cover FIR pipeline fill.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset. Asynchronous assert, active-high. One clock; reset is asynchronous and active-high.
- in_sample  in  DATA_W  filtered sample from the FIR, signed.
- in_valid  in  1  in_sample is valid this cycle. Tie high for a free-running FIR.
- out_data  out  DATA_W  sample at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts out_data this cycle.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: a kept sample was dropped because the FIFO was full.
- clr_ovf  in  1  synchronous clear of overflow.

## Operation

- Skip counter:
  - Counts valid input samples from 0 to SKIP, then saturates.
  - While it is below SKIP, each valid sample is discarded and the phase counter does not advance.
- Phase counter:
  - Runs 0..DECIM-1 after the skip period and wraps to 0.
  - Advances only on in_valid=1.
  - The sample is kept when phase==0.
  - As a result, the kept samples are the valid samples numbered SKIP+1, SKIP+1+DECIM, and so on (1-based).
- Kept sample handling:
  - in_sample is written unmodified, with no rounding or saturation.
  - The FIFO is memory-based and show-ahead, with rd_ptr and wr_ptr each one bit wider than the index.
- Pop: occurs when out_valid && out_ready.
- Push: occurs for a kept sample when (level < FIFO_DEPTH) || pop. A push and pop in the same cycle while full both succeed: level is unchanged and there is no overflow.
- Drop: a kept sample with level==FIFO_DEPTH and no pop is discarded, and overflow is set to 1.
- overflow behaviour:
  - Clears only on clr_ovf=1 or reset.
  - If a drop and clr_ovf occur in the same cycle, set wins and overflow stays 1.
- in_valid=0: no counter or FIFO write activity. A pop can still occur.
- Output conditions:
  - out_valid = (level != 0).
  - out_data = mem[rd_ptr].
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Reset values:
  - out_valid=0, out_data=0, level=0, overflow=0.
  - Skip and phase counters are 0; all memory entries are 0.
  - Reset mid-operation discards FIFO contents and restarts the skip period.

## Timing

- Latency: a kept sample presented at edge N appears with out_valid=1 after edge N, i.e. one cycle. There is no empty-FIFO bypass.
- A pop at edge N presents the next entry, or clears out_valid, after edge N.
- level, overflow and out_valid are registered, or derived combinationally from registers only.
- out_ready has no combinational path to any output other than through registered state.
- Reset assertion takes effect on all outputs immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally. The block's first active edge is the first rising clk edge with rst=0.
- Throughput: one push and one pop per cycle maximum. With DECIM=1 and out_ready=1 held, the output sustains one sample per cycle.

## Test plan

1. Startup and decimation (defaults):
   - Stimulus: rst pulse, then in_valid=1 with in_sample=1,2,3,... on consecutive cycles and out_ready=1.
   - Required: the output sequence is 7,11,15,19,...; the first out_valid occurs the cycle after the sample of value 7 is presented.
   - Required: level never exceeds 1 and overflow=0.
2. Backpressure and overflow:
   - Stimulus: the same ramp as test 1 with out_ready=0.
   - Required: after 35 is written, level=8 and out_valid=1.
   - Required: sample 39 is dropped and overflow=1.
   - Stimulus: raise out_ready.
   - Required: the output drains 7,11,...,35, followed by 47 if the ramp continues. 39 and 43 are lost depending on timing; verify against a reference model.
3. Full plus simultaneous push/pop:
   - Stimulus: fill the FIFO to 8, then assert out_ready=1 for exactly the cycle a kept sample arrives.
   - Required: level stays 8, overflow stays 0, and the head advances by one entry.
4. Overflow clear priority:
   - Stimulus: with overflow=1, pulse clr_ovf on a non-drop cycle.
   - Required: overflow becomes 0 after the edge.
   - Stimulus: pulse clr_ovf on a drop cycle.
   - Required: overflow stays 1.
5. Gapped input:
   - Stimulus: in_valid toggles 1,0,1,0,... carrying the ramp values only on valid cycles, DECIM=4.
   - Required: the output sequence is still 7,11,15; the phase is unaffected by invalid cycles.
6. Asynchronous reset mid-operation:
   - Stimulus: with level=5 and overflow=1, assert rst between clock edges.
   - Required: out_valid=0, level=0 and overflow=0 immediately.
   - Stimulus: after release, restart the ramp at 1.
   - Required: the first output is again 7.
